// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Data-memory responder for a simple stalling CPU. It holds a
//   2^ADDR_W x 16-bit RAM and serves one load or store at a time.
//   While an access is in progress mem_busy stalls the CPU. A load
//   finishes with a single-cycle mem_ready pulse and rd_data registered.
//   A store is posted: it commits on its last busy cycle and never
//   raises mem_ready.
//
//   Handshake: a request (ram_read / ram_write) is accepted only on a
//   rising edge where the FSM is IDLE and rst=0. A request seen in any
//   other state is ignored; the stalled CPU re-presents it once mem_busy
//   drops. The CPU holds addr stable while mem_busy=1. If both strobes
//   are high on an accepting edge, the write wins.
//
//   Optional feature macro: MEM_WAIT_EN
//     defined   -> the busy phase lasts WAIT_CYCLES cycles (1..15)
//     undefined -> the busy phase lasts exactly 1 cycle
//
// Ports
//   clk        in   clock; all state updates on its rising edge
//   rst        in   synchronous active-high reset (RAM is not cleared)
//   addr       in   16-bit word address; only addr[ADDR_W-1:0] is used
//   wr_data    in   16-bit store data
//   ram_read   in   load request
//   ram_write  in   store request
//   mem_busy   out  access in progress, CPU must stall (registered decode)
//   mem_ready  out  load data valid this cycle (registered decode)
//   rd_data    out  16-bit load result, held until the next load completes
// ---------------------------------------------------------------------------
module mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [15:0] wr_data,
   input  logic        ram_read,
   input  logic        ram_write,
   output logic        mem_busy,
   output logic        mem_ready,
   output logic [15:0] rd_data
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_RD = 2'd1,
      BUSY_WR = 2'd2,
      READY   = 2'd3
   } state_e;

`ifdef MEM_WAIT_EN
   localparam logic [3:0] BUSY_LEN = 4'(WAIT_CYCLES);
`else
   localparam logic [3:0] BUSY_LEN = 4'd1;
   // The wait length is fixed at one cycle in this build.
   localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

   localparam int DEPTH = 2 ** ADDR_W;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [15:0]         wdata_q, wdata_d;
   logic [15:0]         rd_data_q, rd_data_d;
   logic                mem_we;

   logic [15:0]         mem_q [DEPTH];

   // Upper address bits are intentionally dropped so addresses wrap.
   if (ADDR_W < 16) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[15:ADDR_W];
   end

   // Next-state / datapath decisions
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rd_data_d = rd_data_q;
      mem_we    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (ram_write) begin
               // Write has priority; a simultaneous read is dropped.
               addr_d  = addr[ADDR_W-1:0];
               wdata_d = wr_data;
               cnt_d   = BUSY_LEN;
               state_d = BUSY_WR;
            end else if (ram_read) begin
               addr_d  = addr[ADDR_W-1:0];
               cnt_d   = BUSY_LEN;
               state_d = BUSY_RD;
            end
         end

         BUSY_WR: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               mem_we  = 1'b1;
               state_d = IDLE;
            end
         end

         BUSY_RD: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               rd_data_d = mem_q[addr_q];
               state_d   = READY;
            end
         end

         READY: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         addr_q    <= '0;
         wdata_q   <= 16'd0;
         rd_data_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rd_data_q <= rd_data_d;
      end
   end

   // RAM has no reset. A reset coinciding with the commit cycle
   // suppresses the write so the uncommitted store is discarded.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign mem_busy  = (state_q == BUSY_RD) || (state_q == BUSY_WR);
   assign mem_ready = (state_q == READY);
   assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Randomized bench for mem_responder. A reference RAM array holds
//   the contents the DUT should have. Load requests push their expected
//   data into exp_q, and an independent monitor pops and compares on every
//   mem_ready. Driver tasks also check busy-phase length and ready timing.
// ---------------------------------------------------------------------------
module tb_mem_responder;

`ifdef MEM_WAIT_EN
  localparam int WAIT_P   = 3;
  localparam int BUSY_LEN = 3;
`else
  localparam int WAIT_P   = 7;
  localparam int BUSY_LEN = 1;
`endif
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int BOUND  = 40;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = 16'd0;
  logic [15:0] wr_data = 16'd0;
  logic        ram_read = 1'b0;
  logic        ram_write = 1'b0;
  logic        mem_busy;
  logic        mem_ready;
  logic [15:0] rd_data;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_P)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wr_data   (wr_data),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .mem_busy  (mem_busy),
    .mem_ready (mem_ready),
    .rd_data   (rd_data)
  );

  // ---------------- scoreboard state ----------------
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] exp_q [$];
  logic [15:0] mon_exp;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every load-ready pulse must match the oldest expected value.
  always @(negedge clk) begin
    if (!rst && mem_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_ready: got rd_data 0x%0h expected no ready pulse at %0t",
                 rd_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_data", {16'd0, rd_data}, {16'd0, mon_exp});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after the accepting edge; returns at the first negedge
  // where mem_busy is low, having counted busy negedges.
  task automatic wait_busy(output int n);
    n = 0;
    @(negedge clk);
    while (mem_busy && n < BOUND) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    int n;
    @(negedge clk);
    addr = a; wr_data = d; ram_write = 1'b1;
    check("req_cycle_busy", {31'd0, mem_busy}, 32'd0);
    @(posedge clk);
    #1 ram_write = 1'b0;
    ref_mem[a % DEPTH] = d;
    wait_busy(n);
    check("wr_busy_len", n, BUSY_LEN);
    check("wr_no_ready", {31'd0, mem_ready}, 32'd0);
  endtask

  task automatic do_read(input logic [15:0] a);
    int n;
    logic [15:0] e;
    e = ref_mem[a % DEPTH];
    @(negedge clk);
    addr = a; ram_read = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 ram_read = 1'b0;
    wait_busy(n);
    check("rd_busy_len", n, BUSY_LEN);
    check("rd_ready_pulse", {31'd0, mem_ready}, 32'd1);
    @(negedge clk);
    check("rd_ready_one_cycle", {31'd0, mem_ready}, 32'd0);
    check("rd_data_hold", {16'd0, rd_data}, {16'd0, e});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [15:0] ra, rd;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, mem_busy}, 32'd0);
    check("reset_ready", {31'd0, mem_ready}, 32'd0);
    check("reset_rd_data", {16'd0, rd_data}, 32'd0);

    // Give every RAM word a known value.
    for (int i = 0; i < DEPTH; i++) do_write(16'(i), 16'($urandom));

    // Load timing: write then read back.
    do_write(16'h0005, 16'hBEEF);
    do_read(16'h0005);

    // Store then load with ram_read held while the store is busy.
    @(negedge clk);
    addr = 16'h0010; wr_data = 16'h1234; ram_write = 1'b1;
    @(posedge clk);
    #1 ram_write = 1'b0; ram_read = 1'b1;
    ref_mem[16'h10] = 16'h1234;
    exp_q.push_back(16'h1234);
    wait_busy(n);
    check("b2b_wr_busy_len", n, BUSY_LEN);
    check("b2b_no_early_ready", {31'd0, mem_ready}, 32'd0);
    @(posedge clk);
    #1 ram_read = 1'b0;
    wait_busy(n);
    check("b2b_rd_busy_len", n, BUSY_LEN);
    check("b2b_ready_pulse", {31'd0, mem_ready}, 32'd1);
    @(negedge clk);

    // Simultaneous read+write: write wins, no ready pulse.
    @(negedge clk);
    addr = 16'h0020; wr_data = 16'h00AA; ram_write = 1'b1; ram_read = 1'b1;
    @(posedge clk);
    #1 ram_write = 1'b0; ram_read = 1'b0;
    ref_mem[16'h20] = 16'h00AA;
    wait_busy(n);
    check("simul_busy_len", n, BUSY_LEN);
    repeat (3) @(negedge clk);
    do_read(16'h0020);

    // Address wrap-around.
    do_write(16'h0103, 16'h5555);
    do_read(16'h0003);

    // Reset in the first BUSY_WR cycle discards the store.
    do_write(16'h0007, 16'h0001);
    @(negedge clk);
    addr = 16'h0007; wr_data = 16'h9999; ram_write = 1'b1;
    @(posedge clk);
    #1 ram_write = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wr_busy", {31'd0, mem_busy}, 32'd0);
    check("rst_wr_rd_data", {16'd0, rd_data}, 32'd0);
    do_read(16'h0007);

    // Reset during a read: no ready pulse, rd_data cleared.
    @(negedge clk);
    addr = 16'h0005; ram_read = 1'b1;
    @(posedge clk);
    #1 ram_read = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (BUSY_LEN + 3) begin
      @(negedge clk);
      check("rst_rd_no_ready", {31'd0, mem_ready}, 32'd0);
    end
    check("rst_rd_rd_data", {16'd0, rd_data}, 32'd0);

    // Requests during reset are ignored.
    @(negedge clk);
    rst = 1'b1; addr = 16'h0030; wr_data = ~ref_mem[16'h30]; ram_write = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; ram_write = 1'b0;
    @(negedge clk);
    check("rst_req_ignored_busy", {31'd0, mem_busy}, 32'd0);
    do_read(16'h0030);

    // Randomized mix of stores and loads.
    for (int i = 0; i < 80; i++) begin
      ra = 16'($urandom);
      rd = 16'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(ra, rd);
      else do_read(ra);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8: the internal RAM holds 2^ADDR_W 16-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2: mem_busy cycles per access when MEM_WAIT_EN is defined; legal range is 1..15.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port addr, input, 16 bits: word address from the CPU ALU output, held stable by the CPU while mem_busy=1.
REQ-006 Port wr_data, input, 16 bits: store data from the CPU register file.
REQ-007 Port ram_read, input, 1 bit: load request.
REQ-008 Port ram_write, input, 1 bit: store request.
REQ-009 Port mem_busy, output, 1 bit: an access is in progress and the CPU must stall.
REQ-010 Port mem_ready, output, 1 bit: load data is valid this cycle.
REQ-011 Port rd_data, output, 16 bits: load result for the register-file input mux.

Function
REQ-012 The block SHALL be an FSM with states IDLE, BUSY_RD, BUSY_WR and READY, plus a 4-bit wait counter.
REQ-013 In IDLE, a sampled ram_write SHALL latch addr[ADDR_W-1:0] and wr_data, load the counter and enter BUSY_WR.
REQ-014 In IDLE, a sampled ram_read with ram_write=0 SHALL latch addr[ADDR_W-1:0], load the counter and enter BUSY_RD.
REQ-015 When ram_read and ram_write are asserted together in IDLE, the write SHALL win and the read SHALL be dropped.
REQ-016 mem_busy SHALL be 1 exactly in BUSY_RD and BUSY_WR; it is a registered state decode with no combinational path from any input.
REQ-017 mem_busy SHALL be 0 in the cycle a request is sampled.
REQ-018 The busy phase SHALL last the number of cycles set by the counter (see Configuration).
REQ-019 The counter SHALL decrement once per busy cycle; the last busy cycle is the one with counter=1.
REQ-020 On the last BUSY_WR cycle, the latched data SHALL be written to RAM at the latched address, and the next state SHALL be IDLE.
  - Stores are posted: the CPU advances without seeing mem_ready, and mem_ready stays 0 for writes.
REQ-021 On the last BUSY_RD cycle, RAM[latched address] SHALL be registered into rd_data, and the next state SHALL be READY.
REQ-022 In READY, mem_ready SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE.
REQ-023 rd_data SHALL hold its value until the next read completes.
REQ-024 ram_read and ram_write SHALL be ignored in every state except IDLE.
  - Any request issued while busy is re-presented by the stalled CPU once mem_busy=0.
REQ-025 Address bits at and above ADDR_W SHALL be ignored, so addresses wrap modulo 2^ADDR_W.
REQ-026 A read issued directly after a write to the same address SHALL return the newly written data.
REQ-027 Minimum load latency SHALL be request cycle + busy cycles + 1 READY cycle.

Reset
REQ-028 When rst=1, the FSM SHALL go to IDLE and mem_busy, mem_ready, rd_data and the counter SHALL all become 0.
REQ-029 Reset during BUSY_WR SHALL discard the uncommitted write.
REQ-030 Reset during BUSY_RD or READY SHALL abort the read with no mem_ready pulse.
REQ-031 RAM contents SHALL NOT be cleared by reset.
REQ-032 Requests present in a cycle with rst=1 SHALL be ignored.

Configuration
REQ-033 The macro MEM_WAIT_EN SHALL select the busy-phase length.
  - Defined: the busy phase lasts WAIT_CYCLES cycles.
  - Undefined: WAIT_CYCLES is ignored and the busy phase lasts exactly 1 cycle.

Verification
REQ-034 Load timing: write 0xBEEF at addr 0x05, then read 0x05 with MEM_WAIT_EN and WAIT_CYCLES=3.
  - Required: mem_busy high for 3 cycles, then mem_ready high for exactly 1 cycle with rd_data=0xBEEF.
REQ-035 Back-to-back store then load: std 0x1234 at addr 0x10, with ram_read held at 0x10 while busy.
  - Required: the read is accepted only after mem_busy falls, and rd_data=0x1234.
REQ-036 Simultaneous request: ram_read=1 and ram_write=1 in IDLE, addr 0x20, wr_data 0x00AA.
  - Required: a write occurs, mem_ready never pulses, and a later read of 0x20 returns 0x00AA.
REQ-037 Wrap-around: with ADDR_W=8, write 0x5555 at addr 0x0103, then read addr 0x0003.
  - Required: returns 0x5555.
REQ-038 Reset during a store: rst=1 in the first BUSY_WR cycle of a write of 0x9999 to addr 0x07, whose old value is 0x0001.
  - Required: mem_busy=0 the next cycle, and a read of 0x07 returns 0x0001.
REQ-039 Without MEM_WAIT_EN: a read shows exactly 1 busy cycle then 1 ready cycle, regardless of WAIT_CYCLES=7.
